// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared widths and grant encoding for the register-file writeback arbiter.
package regfile_wb_arbiter_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;
  localparam int NUM_REGS   = 32;
  localparam int WAIT_CNT_W = 4;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_P0   = 2'd1,
    GNT_P1   = 2'd2
  } grant_e;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback request ports, reservation/hazard lookup and register-file write port.
interface regfile_wb_arbiter_if;
  import regfile_wb_arbiter_pkg::*;

  logic                  Valid0;
  logic [REG_ADDR_W-1:0] Reg0;
  logic [DATA_W-1:0]     Data0;
  logic                  Ready0;
  logic                  Valid1;
  logic [REG_ADDR_W-1:0] Reg1;
  logic [DATA_W-1:0]     Data1;
  logic                  Ready1;
  logic                  ResValid;
  logic [REG_ADDR_W-1:0] ResReg;
  logic [REG_ADDR_W-1:0] ReadReg1;
  logic [REG_ADDR_W-1:0] ReadReg2;
  logic                  Hazard1;
  logic                  Hazard2;
  logic                  RegWrite;
  logic [REG_ADDR_W-1:0] WriteReg;
  logic [DATA_W-1:0]     WriteData;

  modport slave (
    input  Valid0, Reg0, Data0, Valid1, Reg1, Data1,
           ResValid, ResReg, ReadReg1, ReadReg2,
    output Ready0, Ready1, Hazard1, Hazard2, RegWrite, WriteReg, WriteData
  );

  modport master (
    output Valid0, Reg0, Data0, Valid1, Reg1, Data1,
           ResValid, ResReg, ReadReg1, ReadReg2,
    input  Ready0, Ready1, Hazard1, Hazard2, RegWrite, WriteReg, WriteData
  );

endinterface

// File: rtl/regfile_wb_arbiter_scoreboard.sv
// Busy-bit scoreboard: reservations set, accepted writebacks clear, decode looks up hazards.
module regfile_scoreboard
  import regfile_wb_arbiter_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  set_en,
  input  logic [REG_ADDR_W-1:0] set_reg,
  input  logic                  clr_en,
  input  logic [REG_ADDR_W-1:0] clr_reg,
  input  logic                  wr_en,
  input  logic [REG_ADDR_W-1:0] wr_reg,
  input  logic [REG_ADDR_W-1:0] rd_reg1,
  input  logic [REG_ADDR_W-1:0] rd_reg2,
  output logic                  hazard1,
  output logic                  hazard2
);

  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;

  // Set is applied after clear so a same-edge reservation survives its own writeback.
  always_comb begin
    busy_d = busy_q;
    if (clr_en) busy_d[clr_reg] = 1'b0;
    if (set_en) busy_d[set_reg] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end

  // The in-flight term covers the cycle where the write lands on the falling edge.
  assign hazard1 = busy_q[rd_reg1] | (wr_en & (wr_reg == rd_reg1) & (|rd_reg1));
  assign hazard2 = busy_q[rd_reg2] | (wr_en & (wr_reg == rd_reg2) & (|rd_reg2));

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Two-port writeback arbiter with port-1 starvation guard, registered write port and hazard scoreboard.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input logic                  CLK,
  input logic                  RST,
  regfile_wb_arbiter_if.slave  bus
);

  localparam logic [WAIT_CNT_W-1:0] LIMIT = WAIT_CNT_W'(STARVE_LIMIT);

  logic [WAIT_CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic                  reg_write_q, reg_write_d;
  logic [REG_ADDR_W-1:0] write_reg_q, write_reg_d;
  logic [DATA_W-1:0]     write_data_q, write_data_d;
  logic                  ready0, ready1, forced;
  grant_e                grant;
  logic [REG_ADDR_W-1:0] acc_reg;

  always_comb begin
    forced       = (wait_cnt_q == LIMIT);
    ready0       = 1'b0;
    ready1       = 1'b0;
    grant        = GNT_NONE;
    acc_reg      = '0;
    wait_cnt_d   = wait_cnt_q;
    reg_write_d  = 1'b0;
    write_reg_d  = write_reg_q;
    write_data_d = write_data_q;

    if (!RST) begin
      if (forced) begin
        ready1 = bus.Valid1;
      end else begin
        ready0 = bus.Valid0 | ~bus.Valid1;
        ready1 = bus.Valid1 & ~bus.Valid0;
      end
    end

    if (bus.Valid0 && ready0)      grant = GNT_P0;
    else if (bus.Valid1 && ready1) grant = GNT_P1;

    case (grant)
      GNT_P0: begin
        acc_reg      = bus.Reg0;
        write_reg_d  = bus.Reg0;
        write_data_d = bus.Data0;
        reg_write_d  = |bus.Reg0;
      end
      GNT_P1: begin
        acc_reg      = bus.Reg1;
        write_reg_d  = bus.Reg1;
        write_data_d = bus.Data1;
        reg_write_d  = |bus.Reg1;
      end
      default: ;
    endcase

    // Stall counter tracks only a waiting port 1 and pins at the limit.
    if (!bus.Valid1 || grant == GNT_P1) wait_cnt_d = '0;
    else if (wait_cnt_q < LIMIT)        wait_cnt_d = wait_cnt_q + 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wait_cnt_q   <= '0;
      reg_write_q  <= 1'b0;
      write_reg_q  <= '0;
      write_data_q <= '0;
    end else begin
      wait_cnt_q   <= wait_cnt_d;
      reg_write_q  <= reg_write_d;
      write_reg_q  <= write_reg_d;
      write_data_q <= write_data_d;
    end
  end

  regfile_scoreboard u_scoreboard (
    .clk     (CLK),
    .rst     (RST),
    .set_en  (bus.ResValid),
    .set_reg (bus.ResReg),
    .clr_en  (grant != GNT_NONE),
    .clr_reg (acc_reg),
    .wr_en   (reg_write_q),
    .wr_reg  (write_reg_q),
    .rd_reg1 (bus.ReadReg1),
    .rd_reg2 (bus.ReadReg2),
    .hazard1 (bus.Hazard1),
    .hazard2 (bus.Hazard2)
  );

  assign bus.Ready0    = ready0;
  assign bus.Ready1    = ready1;
  assign bus.RegWrite  = reg_write_q;
  assign bus.WriteReg  = write_reg_q;
  assign bus.WriteData = write_data_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Randomized and directed bench for regfile_wb_arbiter against a behavioural model.
module tb_regfile_wb_arbiter;

  localparam int LIMIT = 4;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  regfile_wb_arbiter_if bus ();

  regfile_wb_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Behavioural model state
  bit [31:0]   m_busy;
  int          m_stall;
  bit          m_wen;
  logic [4:0]  m_wreg;
  logic [31:0] m_wdata;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy  = '0;
    m_stall = 0;
    m_wen   = 1'b0;
    m_wreg  = '0;
    m_wdata = '0;
  endtask

  task automatic model_ready(output bit r0, output bit r1);
    r0 = 1'b0;
    r1 = 1'b0;
    if (!rst) begin
      if (m_stall == LIMIT) begin
        r1 = bus.Valid1;
      end else if (bus.Valid0) begin
        r0 = 1'b1;
      end else if (bus.Valid1) begin
        r1 = 1'b1;
      end else begin
        r0 = 1'b1;
      end
    end
  endtask

  function automatic bit model_hazard(input logic [4:0] rd);
    return m_busy[rd] || (m_wen && m_wreg == rd && rd != 0);
  endfunction

  task automatic settle();
    bit e0, e1;
    #1;
    model_ready(e0, e1);
    check_eq("ready0",    bus.Ready0,    e0);
    check_eq("ready1",    bus.Ready1,    e1);
    check_eq("hazard1",   bus.Hazard1,   model_hazard(bus.ReadReg1));
    check_eq("hazard2",   bus.Hazard2,   model_hazard(bus.ReadReg2));
    check_eq("regwrite",  bus.RegWrite,  m_wen);
    check_eq("writereg",  bus.WriteReg,  m_wreg);
    check_eq("writedata", bus.WriteData, m_wdata);
  endtask

  task automatic clock();
    bit          r0, r1, acc;
    logic [4:0]  areg;
    logic [31:0] adata;
    model_ready(r0, r1);
    @(posedge clk);
    #1;
    if (rst) begin
      model_reset();
    end else begin
      acc   = 1'b0;
      areg  = '0;
      adata = '0;
      if (bus.Valid0 && r0) begin
        acc = 1'b1; areg = bus.Reg0; adata = bus.Data0;
      end else if (bus.Valid1 && r1) begin
        acc = 1'b1; areg = bus.Reg1; adata = bus.Data1;
      end
      if (acc) begin
        m_wen   = (areg != 0);
        m_wreg  = areg;
        m_wdata = adata;
        m_busy[areg] = 1'b0;
      end else begin
        m_wen = 1'b0;
      end
      if (bus.ResValid && bus.ResReg != 0) m_busy[bus.ResReg] = 1'b1;
      m_busy[0] = 1'b0;
      if (!bus.Valid1 || (bus.Valid1 && r1)) m_stall = 0;
      else if (m_stall < LIMIT)              m_stall++;
    end
  endtask

  task automatic idle();
    bus.Valid0 = 0; bus.Reg0 = 0; bus.Data0 = 0;
    bus.Valid1 = 0; bus.Reg1 = 0; bus.Data1 = 0;
    bus.ResValid = 0; bus.ResReg = 0;
    bus.ReadReg1 = 0; bus.ReadReg2 = 0;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    @(posedge clk);
    @(posedge clk);
    #1;
    model_reset();
    settle();
    check_eq("rst_regwrite",  bus.RegWrite,  0);
    check_eq("rst_writereg",  bus.WriteReg,  0);
    check_eq("rst_writedata", bus.WriteData, 0);
    clock();
    rst = 1'b0;

    // Single port-0 write
    bus.Valid0 = 1; bus.Reg0 = 5; bus.Data0 = 32'hDEADBEEF;
    settle();
    check_eq("p0_ready0", bus.Ready0, 1);
    clock();
    idle();
    settle();
    check_eq("p0_regwrite",  bus.RegWrite,  1);
    check_eq("p0_writereg",  bus.WriteReg,  5);
    check_eq("p0_writedata", bus.WriteData, 32'hDEADBEEF);
    clock();
    settle();
    check_eq("p0_regwrite_off", bus.RegWrite, 0);
    clock();

    // Starvation: both ports held for six cycles
    for (int i = 0; i < 6; i++) begin
      bus.Valid0 = 1; bus.Reg0 = 1; bus.Data0 = 32'(i);
      bus.Valid1 = 1; bus.Reg1 = 2; bus.Data1 = 32'h100 + 32'(i);
      settle();
      check_eq("starve_ready0", bus.Ready0, (i == 4) ? 0 : 1);
      check_eq("starve_ready1", bus.Ready1, (i == 4) ? 1 : 0);
      clock();
    end
    idle();
    settle();
    clock();

    // Reservation hazard cleared by a port-1 write
    bus.ResValid = 1; bus.ResReg = 9; bus.ReadReg1 = 9;
    settle();
    clock();
    bus.ResValid = 0;
    settle();
    check_eq("res9_hazard", bus.Hazard1, 1);
    clock();
    bus.Valid1 = 1; bus.Reg1 = 9; bus.Data1 = 32'h99;
    settle();
    check_eq("res9_hazard_acc", bus.Hazard1, 1);
    check_eq("res9_ready1", bus.Ready1, 1);
    clock();
    bus.Valid1 = 0;
    settle();
    check_eq("res9_hazard_inflight", bus.Hazard1, 1);
    check_eq("res9_regwrite", bus.RegWrite, 1);
    clock();
    settle();
    check_eq("res9_hazard_clear", bus.Hazard1, 0);
    clock();

    // Same-edge reservation and accept of register 7; write to register 0
    bus.ResValid = 1; bus.ResReg = 7; bus.Valid0 = 1; bus.Reg0 = 7; bus.Data0 = 32'h77;
    settle();
    clock();
    idle();
    bus.ReadReg1 = 7;
    settle();
    clock();
    settle();
    check_eq("set_wins_hazard", bus.Hazard1, 1);
    bus.Valid0 = 1; bus.Reg0 = 0; bus.Data0 = 32'h1234;
    settle();
    check_eq("r0_ready0", bus.Ready0, 1);
    clock();
    idle();
    settle();
    check_eq("r0_regwrite", bus.RegWrite, 0);
    clock();

    // Reset right after a port-1 accept of a busy register
    bus.ResValid = 1; bus.ResReg = 3;
    settle();
    clock();
    idle();
    bus.Valid1 = 1; bus.Reg1 = 3; bus.Data1 = 32'h33; bus.ReadReg1 = 3;
    settle();
    clock();
    rst = 1'b1;
    bus.Valid0 = 1; bus.Valid1 = 1; bus.Reg0 = 4; bus.Reg1 = 3;
    settle();
    check_eq("rst_mid_ready0", bus.Ready0, 0);
    check_eq("rst_mid_ready1", bus.Ready1, 0);
    clock();
    rst = 1'b0;
    bus.Valid0 = 1; bus.Valid1 = 1; bus.ResValid = 0; bus.ReadReg1 = 3; bus.ReadReg2 = 7;
    settle();
    check_eq("rst_mid_regwrite", bus.RegWrite, 0);
    check_eq("rst_mid_hazard1", bus.Hazard1, 0);
    check_eq("rst_mid_hazard2", bus.Hazard2, 0);
    check_eq("rst_mid_wait_ready0", bus.Ready0, 1);
    clock();

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      rst          = ($urandom_range(0, 59) == 0);
      bus.Valid0   = ($urandom_range(0, 99) < 45);
      bus.Reg0     = 5'($urandom_range(0, 7));
      bus.Data0    = $urandom;
      bus.Valid1   = ($urandom_range(0, 99) < 65);
      bus.Reg1     = 5'($urandom_range(0, 7));
      bus.Data1    = $urandom;
      bus.ResValid = ($urandom_range(0, 99) < 30);
      bus.ResReg   = 5'($urandom_range(0, 7));
      bus.ReadReg1 = 5'($urandom_range(0, 7));
      bus.ReadReg2 = 5'($urandom_range(0, 31));
      settle();
      clock();
    end
    rst = 1'b0;
    idle();
    settle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 Parameter: STARVE_LIMIT, default 4, meaning: consecutive stalled cycles of port 1 before port 1 is forced priority; legal range 1..15.
REQ-002 CLK  input  1  sole clock; all state updates on rising edge.
REQ-003 RST  input  1  reset, synchronous, active-high.
REQ-004 Valid0  input  1  pipeline writeback request (port 0, default priority).
REQ-005 Reg0  input  5  port 0 destination register.
REQ-006 Data0  input  32  port 0 write data.
REQ-007 Ready0  output  1  port 0 accepted this cycle when Valid0&Ready0.
REQ-008 Valid1, Reg1 (5), Data1 (32)  input  multi-cycle unit (mult/div/load) request, port 1.
REQ-009 Ready1  output  1  port 1 accept, same rule as Ready0.
REQ-010 ResValid  input  1; ResReg  input  5  issue-stage reservation of a future destination register.
REQ-011 ReadReg1, ReadReg2  input  5  decode-stage source registers for hazard check.
REQ-012 Hazard1, Hazard2  output  1  source register has a pending write.
REQ-013 RegWrite  output  1; WriteReg  output  5; WriteData  output  32  drive the register file write port.

Function
REQ-014 Ready0/Ready1 are combinational from Valid0, Valid1, forced-priority flag; at most one asserted per cycle.
REQ-015 Normal priority: Ready0=1 whenever Valid0=1 (or Valid0=0, Valid1=0); Ready1=Valid1&~Valid0.
REQ-016 Forced priority (WaitCnt==STARVE_LIMIT): Ready1=Valid1, Ready0=0.
REQ-017 WaitCnt (4 bits): +1 each cycle Valid1&~Ready1; cleared on port 1 accept or when Valid1=0; saturates at STARVE_LIMIT.
REQ-018 On an accept edge, WriteReg/WriteData load the granted port's Reg/Data; RegWrite loads 1 if Reg≠0, else 0.
REQ-019 With no accept, RegWrite loads 0; WriteReg/WriteData hold.
REQ-020 Latency: request accepted at rising edge N -> RegWrite high for exactly cycle N..N+1 -> register file captures on the falling edge inside that cycle; back-to-back accepts give consecutive one-cycle writes.
REQ-021 Requests to register 0 are accepted (handshake completes) but never produce RegWrite=1.
REQ-022 Scoreboard: 32 busy bits; ResValid&ResReg≠0 sets busy[ResReg] at rising edge; accept with Reg=r clears busy[r] at same edge.
REQ-023 Simultaneous set and clear of same register: set wins (busy stays 1).
REQ-024 Reservation of register 0 ignored; busy[0] is constant 0.
REQ-025 Hazardn = busy[ReadRegn] | (RegWrite & WriteReg==ReadRegn & ReadRegn≠0); combinational, covers the in-flight negedge write.
REQ-026 Accept for a register not busy is legal (no error); busy bit remains 0.

Reset
REQ-027 RST=1 at rising edge: RegWrite=0, WriteReg=0, WriteData=0, all busy bits 0, WaitCnt=0; Ready0/Ready1 forced 0 while RST=1.
REQ-028 Reset mid-operation discards any accepted-but-unwritten entry (RegWrite=0 next cycle) and all reservations; no handshake completes during reset.

Structure
REQ-029 Shared package holds REG_ADDR_W=5, DATA_W=32, NUM_REGS=32 and WaitCnt width.
REQ-030 Scoreboard (busy bits, set/clear, hazard lookup) is sub-module regfile_scoreboard; arbitration, starvation counter and output registers stay in the top.
REQ-031 No memory inferred; busy bits are flops.

Verification
REQ-032 Valid0=1 Reg0=5 Data0=0xDEADBEEF alone -> Ready0=1; next cycle RegWrite=1 WriteReg=5 WriteData=0xDEADBEEF; following cycle RegWrite=0.
REQ-033 Valid0 and Valid1 held for 6 cycles, STARVE_LIMIT=4 -> port 0 granted 4 cycles, cycle 5 Ready1=1 Ready0=0, WaitCnt returns 0, port 0 resumes.
REQ-034 ResValid ResReg=9, then ReadReg1=9 -> Hazard1=1 until port 1 write to 9 accepted; Hazard1 stays 1 during RegWrite cycle, 0 after.
REQ-035 Same edge: ResReg=7 reserved and port 0 accept Reg0=7 -> busy[7]=1 afterwards; Valid0 Reg0=0 -> Ready0=1, RegWrite stays 0.
REQ-036 RST asserted one cycle after accept of Reg1=3 with busy[3]=1 -> RegWrite=0, busy all 0, WaitCnt=0, Ready0=Ready1=0 during reset.
